num_capture: RTL and testbench
==============================

NUM_CAPTURE -- requirements
Module: num_capture

Interface
REQ-001 The module SHALL have parameter NDIG, default 3, meaning the maximum number of decimal digits per entry.
REQ-002 The module SHALL have parameter RELEASE_CYCLES, default 4, meaning the consecutive load_num-low cycles needed before a new code is accepted.
REQ-003 clk_div  input  1  keypad-domain clock, all state on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 num  input  4  key code from the keypad scanner: 0-9 digit, 0xA sign, 0xB enter, 0xC clear, 0xD-0xF unused.
REQ-006 load_num  input  1  scanner strobe; num is valid while high; repeats while a key is held.
REQ-007 bcd  output  4*NDIG  digits being entered, least significant digit in [3:0], for display.
REQ-008 ndig  output  2  count of digits entered, 0..NDIG.
REQ-009 neg  output  1  pending sign of the entry being typed.
REQ-010 value  output  11  signed two's-complement result of the last enter, range -999..999.
REQ-011 valid  output  1  one-cycle pulse when value is updated.
REQ-012 busy  output  1  high while state is ENTRY.

Function
REQ-013 Acceptance: a code SHALL be accepted at a rising edge where load_num=1 and armed=1; accepting clears armed and the release counter.
REQ-014 While armed=0: load_num=1 resets the release counter; load_num=0 increments it; armed SHALL set at the edge ending the RELEASE_CYCLES-th consecutive low cycle.
REQ-015 The FSM SHALL have three states: EMPTY (no digits), ENTRY (at least 1 digit), DONE (result issued).
REQ-016 Digit d in EMPTY or ENTRY with ndig<NDIG: bcd shifts left 4 and takes d in [3:0]; accum = accum*10+d; ndig+1; state ENTRY.
REQ-017 Digit with ndig=NDIG SHALL be ignored, but still consumes acceptance and disarms.
REQ-018 Leading zeros SHALL count as digits.
REQ-019 Sign 0xA in EMPTY or ENTRY SHALL toggle neg. In DONE it SHALL clear bcd/accum/ndig, set neg=1 and go to EMPTY.
REQ-020 Enter 0xB in ENTRY: value = neg ? -accum : accum; valid=1 for the single next cycle; state DONE; bcd, ndig and neg are held for display.
REQ-021 Enter in EMPTY or DONE SHALL be ignored, with no valid pulse.
REQ-022 Negative zero SHALL yield value=0.
REQ-023 Clear 0xC in any state SHALL set bcd=0, accum=0, ndig=0, neg=0 and state EMPTY; value SHALL be unchanged.
REQ-024 Digit in DONE SHALL start a new entry: clear everything, then load that digit as in REQ-016, with neg=0 and state ENTRY.
REQ-025 Codes 0xD-0xF SHALL be ignored but still disarm.
REQ-026 Latency: all register updates SHALL occur at the accepting edge, and valid is high in the following cycle only.
REQ-027 accum SHALL be 10 bits unsigned, with no overflow possible for NDIG=3.

Reset
REQ-028 On rst=1 at an edge: state EMPTY, bcd=0, ndig=0, neg=0, accum=0, value=0, valid=0, busy=0, armed=1, release counter 0.
REQ-029 Reset SHALL take priority over any simultaneous load_num, including mid-entry.

Structure
REQ-030 Package num_capture_pkg SHALL hold the key-code constants (KEY_SIGN=0xA, KEY_ENTER=0xB, KEY_CLEAR=0xC), the state enum {EMPTY, ENTRY, DONE}, and the width constants.
REQ-031 Repeat suppression SHALL be a sub-module key_guard (inputs clk_div, rst, load_num; output accept), parameterised by RELEASE_CYCLES.

Verification
REQ-032 Keys 1,2,3,B, each a single strobe separated by 4 low cycles -> bcd=0x123, ndig=3, value=123, one valid pulse, state DONE.
REQ-033 Keys A,4,5,B -> neg=1, value=-45 (11'h7D3), valid pulse once.
REQ-034 num=7 with load_num toggling 1,0 for 10 cycles, then 4 low cycles, then B -> exactly one digit accepted, value=7.
REQ-035 Keys 9,9,9,9,B -> fourth 9 ignored, ndig=3, value=999.
REQ-036 Keys 5,C,B -> no valid, state EMPTY, value unchanged. Then A,0,B -> value=0, valid=1.
REQ-037 rst asserted after keys 1,2 -> next cycle all outputs at reset values. Then 3,B -> value=3.

Source files
------------

// File: rtl/num_capture_pkg.sv
// Shared definitions for the keypad number-capture block.
// Holds the key-code constants, the entry FSM state type, the datapath
// widths and the sign helper used to form the signed result.
package num_capture_pkg;

  localparam int KEY_W   = 4;   // keypad scanner code width
  localparam int ACCUM_W = 10;  // unsigned magnitude, holds up to 999
  localparam int VALUE_W = 11;  // signed result, -999..999
  localparam int NDIG_W  = 2;   // digit counter width, 0..3

  localparam logic [KEY_W-1:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [KEY_W-1:0] KEY_SIGN      = 4'hA;
  localparam logic [KEY_W-1:0] KEY_ENTER     = 4'hB;
  localparam logic [KEY_W-1:0] KEY_CLEAR     = 4'hC;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // no digits typed yet
    ENTRY = 2'd1,  // at least one digit typed
    DONE  = 2'd2   // result issued, digits held for display
  } state_t;

  // Turns the unsigned magnitude into the signed result. A negative zero
  // comes out as plain zero because -0 == 0 in two's complement.
  function automatic logic signed [VALUE_W-1:0] apply_sign(
    input logic [ACCUM_W-1:0] mag,
    input logic               neg
  );
    logic signed [VALUE_W-1:0] s;
    s = signed'({1'b0, mag});
    return neg ? -s : s;
  endfunction

endpackage

// File: rtl/num_capture_if.sv
// Keypad-to-capture bus.
// master: keypad scanner side, drives num/load_num, observes the results.
// slave : num_capture, consumes num/load_num, drives bcd, ndig, neg,
//         value, valid and busy.
interface num_capture_if #(
  parameter int NDIG = 3
);
  import num_capture_pkg::*;

  logic [KEY_W-1:0]          num;
  logic                      load_num;
  logic [4*NDIG-1:0]         bcd;
  logic [NDIG_W-1:0]         ndig;
  logic                      neg;
  logic signed [VALUE_W-1:0] value;
  logic                      valid;
  logic                      busy;

  modport master (
    output num, load_num,
    input  bcd, ndig, neg, value, valid, busy
  );

  modport slave (
    input  num, load_num,
    output bcd, ndig, neg, value, valid, busy
  );

endinterface

// File: rtl/num_capture_key_guard.sv
// key_guard: key repeat suppression.
// The scanner keeps strobing load_num while a key is held. One strobe is
// accepted, then the guard stays disarmed until load_num has been low for
// RELEASE_CYCLES consecutive cycles.
// Ports: clk_div (clock), rst (sync, active-high), load_num (strobe in),
//        accept (high in the cycle a strobe is taken).
module key_guard #(
  parameter int RELEASE_CYCLES = 4
) (
  input  logic clk_div,
  input  logic rst,
  input  logic load_num,
  output logic accept
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);

  logic             armed;
  logic [CNT_W-1:0] release_cnt;

  assign accept = load_num & armed;

  always_ff @(posedge clk_div) begin
    if (rst) begin
      armed       <= 1'b1;
      release_cnt <= '0;
    end else if (armed) begin
      if (load_num) begin
        armed       <= 1'b0;
        release_cnt <= '0;
      end
    end else if (load_num) begin
      // any strobe while disarmed restarts the release window
      release_cnt <= '0;
    end else if (release_cnt == CNT_W'(RELEASE_CYCLES - 1)) begin
      armed       <= 1'b1;
      release_cnt <= '0;
    end else begin
      release_cnt <= release_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/num_capture.sv
// num_capture: collects keypad digits into a signed decimal number.
// Digits shift into a BCD display register and a binary accumulator; the
// sign key toggles the pending sign, enter issues the signed result with a
// one-cycle valid pulse, clear empties the entry.
// Ports: clk_div (clock), rst (sync, active-high),
//        bus (num_capture_if.slave: num/load_num in; bcd, ndig, neg,
//        value, valid, busy out).
module num_capture
  import num_capture_pkg::*;
#(
  parameter int NDIG           = 3,
  parameter int RELEASE_CYCLES = 4
) (
  input  logic         clk_div,
  input  logic         rst,
  num_capture_if.slave bus
);

  localparam int BCD_W = 4 * NDIG;

  logic accept;

  state_t                    state_q, state_n;
  logic [BCD_W-1:0]          bcd_q, bcd_n;
  logic [ACCUM_W-1:0]        accum_q, accum_n;
  logic [NDIG_W-1:0]         ndig_q, ndig_n;
  logic                      neg_q, neg_n;
  logic signed [VALUE_W-1:0] value_q, value_n;
  logic                      valid_q, valid_n;

  key_guard #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_key_guard (
    .clk_div (clk_div),
    .rst     (rst),
    .load_num(bus.load_num),
    .accept  (accept)
  );

  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_q <= EMPTY;
      bcd_q   <= '0;
      accum_q <= '0;
      ndig_q  <= '0;
      neg_q   <= 1'b0;
      value_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      bcd_q   <= bcd_n;
      accum_q <= accum_n;
      ndig_q  <= ndig_n;
      neg_q   <= neg_n;
      value_q <= value_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    bcd_n   = bcd_q;
    accum_n = accum_q;
    ndig_n  = ndig_q;
    neg_n   = neg_q;
    value_n = value_q;
    valid_n = 1'b0;

    if (accept) begin
      if (bus.num <= KEY_DIGIT_MAX) begin
        if (state_q == DONE) begin
          // a digit after a result starts a fresh positive entry
          bcd_n   = {{(BCD_W-KEY_W){1'b0}}, bus.num};
          accum_n = ACCUM_W'(bus.num);
          ndig_n  = NDIG_W'(1);
          neg_n   = 1'b0;
          state_n = ENTRY;
        end else if (ndig_q < NDIG_W'(NDIG)) begin
          bcd_n   = {bcd_q[BCD_W-KEY_W-1:0], bus.num};
          accum_n = accum_q * ACCUM_W'(10) + ACCUM_W'(bus.num);
          ndig_n  = ndig_q + NDIG_W'(1);
          state_n = ENTRY;
        end
      end else begin
        case (bus.num)
          KEY_SIGN: begin
            if (state_q == DONE) begin
              // sign first after a result: new entry that starts negative
              bcd_n   = '0;
              accum_n = '0;
              ndig_n  = '0;
              neg_n   = 1'b1;
              state_n = EMPTY;
            end else begin
              neg_n = ~neg_q;
            end
          end
          KEY_ENTER: begin
            if (state_q == ENTRY) begin
              value_n = apply_sign(accum_q, neg_q);
              valid_n = 1'b1;
              state_n = DONE;
            end
          end
          KEY_CLEAR: begin
            bcd_n   = '0;
            accum_n = '0;
            ndig_n  = '0;
            neg_n   = 1'b0;
            state_n = EMPTY;
          end
          default: ;  // unused codes only consume the strobe
        endcase
      end
    end
  end

  assign bus.bcd   = bcd_q;
  assign bus.ndig  = ndig_q;
  assign bus.neg   = neg_q;
  assign bus.value = value_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q == ENTRY);

endmodule

// File: tb/tb_num_capture.sv
module tb_num_capture;
  localparam int NDIG = 3;
  localparam int RC   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  num_capture_if #(.NDIG(NDIG)) bus ();

  num_capture #(.NDIG(NDIG), .RELEASE_CYCLES(RC)) dut (
    .clk_div(clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  int n_chk   = 0;
  int n_pass  = 0;
  int n_pulse = 0;

  // Reference model: an entry is a list of typed digits plus a sign.
  int m_digits[$];
  bit m_neg, m_done, m_armed, m_valid;
  int m_low, m_value;

  function automatic int model_mag();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  function automatic logic [4*NDIG-1:0] model_bcd();
    logic [4*NDIG-1:0] b = '0;
    foreach (m_digits[i]) b = (b << 4) | (4*NDIG)'(m_digits[i]);
    return b;
  endfunction

  function automatic bit model_busy();
    return !m_done && (m_digits.size() > 0);
  endfunction

  task automatic model_key(input int k);
    if (k <= 9) begin
      if (m_done) begin m_digits.delete(); m_neg = 0; m_done = 0; end
      if (m_digits.size() < NDIG) m_digits.push_back(k);
    end else if (k == 10) begin
      if (m_done) begin m_digits.delete(); m_neg = 1; m_done = 0; end
      else m_neg = !m_neg;
    end else if (k == 11) begin
      if (!m_done && m_digits.size() > 0) begin
        m_value = m_neg ? -model_mag() : model_mag();
        m_valid = 1;
        m_done  = 1;
      end
    end else if (k == 12) begin
      m_digits.delete(); m_neg = 0; m_done = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit l, input bit r);
    m_valid = 0;
    if (r) begin
      m_digits.delete(); m_neg = 0; m_done = 0;
      m_armed = 1; m_low = 0; m_value = 0;
    end else if (l) begin
      if (m_armed) begin m_armed = 0; model_key(k); end
      m_low = 0;
    end else if (!m_armed) begin
      m_low++;
      if (m_low >= RC) begin m_armed = 1; m_low = 0; end
    end
  endtask

  task automatic step(input logic [3:0] k, input logic l, input logic r);
    bus.num = k; bus.load_num = l; rst = r;
    @(posedge clk);
    model_edge(int'(k), l, r);
    #1;
    if (bus.valid === 1'b1) n_pulse++;
  endtask

  task automatic press(input logic [3:0] k);
    step(k, 1'b1, 1'b0);
    repeat (RC) step(4'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b0);
    n_chk++;
    if (bus.bcd !== 12'h000 || bus.ndig !== 2'd0 || bus.neg !== 1'b0 ||
        bus.value !== 11'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_state got bcd=%h ndig=%0d neg=%b value=%h valid=%b busy=%b exp all zero",
               bus.bcd, bus.ndig, bus.neg, bus.value, bus.valid, bus.busy);
    else n_pass++;
  endtask

  task automatic test_basic();
    n_pulse = 0;
    press(4'h1); press(4'h2);
    n_chk++;
    if (bus.busy !== 1'b1 || bus.ndig !== 2'd2 || bus.bcd !== 12'h012)
      $display("FAIL basic_mid got busy=%b ndig=%0d bcd=%h exp 1 2 012", bus.busy, bus.ndig, bus.bcd);
    else n_pass++;
    press(4'h3); press(4'hB);
    n_chk++;
    if (bus.bcd !== 12'h123 || bus.ndig !== 2'd3 || bus.value !== 11'sd123 || bus.busy !== 1'b0)
      $display("FAIL basic_result got bcd=%h ndig=%0d value=%0d busy=%b exp 123 3 123 0",
               bus.bcd, bus.ndig, bus.value, bus.busy);
    else n_pass++;
    n_chk++;
    if (n_pulse != 1) $display("FAIL basic_valid got %0d pulses exp 1", n_pulse);
    else n_pass++;
  endtask

  task automatic test_negative();
    n_pulse = 0;
    press(4'hA); press(4'h4); press(4'h5); press(4'hB);
    n_chk++;
    if (bus.neg !== 1'b1 || bus.value !== 11'h7D3)
      $display("FAIL neg_result got neg=%b value=%h exp 1 7d3", bus.neg, bus.value);
    else n_pass++;
    n_chk++;
    if (n_pulse != 1) $display("FAIL neg_valid got %0d pulses exp 1", n_pulse);
    else n_pass++;
  endtask

  task automatic test_repeat();
    n_pulse = 0;
    for (int i = 0; i < 10; i++) step(4'h7, (i % 2 == 0), 1'b0);
    repeat (RC) step(4'h0, 1'b0, 1'b0);
    n_chk++;
    if (bus.ndig !== 2'd1 || bus.bcd !== 12'h007 || bus.neg !== 1'b0)
      $display("FAIL repeat_digits got ndig=%0d bcd=%h neg=%b exp 1 007 0", bus.ndig, bus.bcd, bus.neg);
    else n_pass++;
    press(4'hB);
    n_chk++;
    if (bus.value !== 11'sd7 || n_pulse != 1)
      $display("FAIL repeat_value got value=%0d pulses=%0d exp 7 1", bus.value, n_pulse);
    else n_pass++;
  endtask

  task automatic test_overflow();
    repeat (4) press(4'h9);
    n_chk++;
    if (bus.ndig !== 2'd3 || bus.bcd !== 12'h999)
      $display("FAIL overflow_digits got ndig=%0d bcd=%h exp 3 999", bus.ndig, bus.bcd);
    else n_pass++;
    press(4'hB);
    n_chk++;
    if (bus.value !== 11'sd999) $display("FAIL overflow_value got %0d exp 999", bus.value);
    else n_pass++;
  endtask

  task automatic test_clear();
    n_pulse = 0;
    press(4'h5); press(4'hC); press(4'hB);
    n_chk++;
    if (n_pulse != 0 || bus.busy !== 1'b0 || bus.ndig !== 2'd0 || bus.bcd !== 12'h000 ||
        bus.value !== 11'sd999)
      $display("FAIL clear_state got pulses=%0d busy=%b ndig=%0d bcd=%h value=%0d exp 0 0 0 000 999",
               n_pulse, bus.busy, bus.ndig, bus.bcd, bus.value);
    else n_pass++;
    press(4'hA); press(4'h0); press(4'hB);
    n_chk++;
    if (bus.value !== 11'd0 || n_pulse != 1 || bus.neg !== 1'b1)
      $display("FAIL negzero got value=%0d pulses=%0d neg=%b exp 0 1 1", bus.value, n_pulse, bus.neg);
    else n_pass++;
  endtask

  task automatic test_sign_done();
    press(4'hA);
    n_chk++;
    if (bus.neg !== 1'b1 || bus.ndig !== 2'd0 || bus.bcd !== 12'h000 || bus.value !== 11'd0)
      $display("FAIL sign_done got neg=%b ndig=%0d bcd=%h value=%0d exp 1 0 000 0",
               bus.neg, bus.ndig, bus.bcd, bus.value);
    else n_pass++;
    press(4'hD); press(4'h8); press(4'hB);
    n_chk++;
    if (bus.value !== -11'sd8 || bus.ndig !== 2'd1)
      $display("FAIL unused_code got value=%0d ndig=%0d exp -8 1", bus.value, bus.ndig);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    press(4'h1); press(4'h2);
    step(4'h3, 1'b1, 1'b1);
    n_chk++;
    if (bus.bcd !== 12'h000 || bus.ndig !== 2'd0 || bus.neg !== 1'b0 ||
        bus.value !== 11'd0 || bus.valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_mid got bcd=%h ndig=%0d neg=%b value=%h valid=%b busy=%b exp all zero",
               bus.bcd, bus.ndig, bus.neg, bus.value, bus.valid, bus.busy);
    else n_pass++;
    step(4'h0, 1'b0, 1'b0);
    press(4'h3); press(4'hB);
    n_chk++;
    if (bus.value !== 11'sd3 || bus.bcd !== 12'h003)
      $display("FAIL reset_mid_after got value=%0d bcd=%h exp 3 003", bus.value, bus.bcd);
    else n_pass++;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 600; i++) begin
      logic [3:0] k;
      logic l, r;
      k = 4'($urandom_range(0, 15));
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(k, l, r);
      n_chk++;
      if (bus.bcd !== model_bcd() || bus.ndig !== 2'(m_digits.size()) || bus.neg !== m_neg ||
          bus.value !== 11'(m_value) || bus.valid !== m_valid || bus.busy !== model_busy()) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d got bcd=%h ndig=%0d neg=%b value=%0d valid=%b busy=%b exp %h %0d %b %0d %b %b",
                   i, bus.bcd, bus.ndig, bus.neg, bus.value, bus.valid, bus.busy,
                   model_bcd(), m_digits.size(), m_neg, m_value, m_valid, model_busy());
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    bus.num = 4'h0;
    bus.load_num = 1'b0;
    test_reset();
    test_basic();
    test_negative();
    test_repeat();
    test_overflow();
    test_clear();
    test_sign_done();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
